// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 receive path.
//   ps2_state_t    : receiver FSM encoding (IDLE/DATA/PARITY/STOP, 2 bits)
//   PS2_EXT_CODE   : extended-key prefix byte (E0)
//   PS2_BREAK_CODE : key-release prefix byte (F0)
//   PS2_FRAME_BITS : bits per frame (start + 8 data + parity + stop)
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter -- synchronises the raw PS/2 pins, debounces ps2_clk and
// produces a one-cycle pulse on each debounced falling edge.
//   clk, reset : system clock, asynchronous active-high reset
//   ps2_clk    : raw PS/2 clock pin
//   ps2_data   : raw PS/2 data pin
//   fall       : one-cycle pulse, debounced ps2_clk went 1->0
//   data_s     : synchronised ps2_data (sample it while fall is high)
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    logic [1:0]            clk_sync_reg;
    logic [1:0]            data_sync_reg;
    logic [FILTER_LEN-1:0] filt_sr_reg;
    logic                  filt_reg;
    logic                  filt_next;
    logic                  fall_reg;

    // Level changes only once the whole window agrees; anything shorter
    // than FILTER_LEN cycles is treated as noise and the old level is held.
    always_comb begin
        filt_next = filt_reg;
        if (&filt_sr_reg) begin
            filt_next = 1'b1;
        end else if (~|filt_sr_reg) begin
            filt_next = 1'b0;
        end
    end

    // Synchronisers come out of reset high (idle bus level) so that no
    // spurious falling edge is seen right after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            filt_sr_reg   <= '1;
            filt_reg      <= 1'b1;
            fall_reg      <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            filt_sr_reg   <= {filt_sr_reg[FILTER_LEN-2:0], clk_sync_reg[1]};
            filt_reg      <= filt_next;
            fall_reg      <= filt_reg & ~filt_next;
        end
    end

    assign fall   = fall_reg;
    assign data_s = data_sync_reg[1];

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame -- PS/2 keyboard receiver: deserialises 11-bit frames
// (start, 8 data LSB-first, odd parity, stop), checks framing and parity,
// and aborts stalled frames with a watchdog.
//   clk, reset    : system clock, asynchronous active-high reset
//   ps2_clk/data  : raw PS/2 pins
//   rx_data       : last correctly received byte
//   rx_valid      : one-cycle pulse, rx_data updated
//   rx_parity_err : one-cycle pulse, parity check failed
//   rx_frame_err  : one-cycle pulse, bad start or stop bit
//   rx_timeout    : one-cycle pulse, frame aborted by watchdog
//   busy          : high while a frame is in progress
//   rx_break      : F0 prefix preceded the current byte
//   rx_ext        : E0 prefix preceded the current byte
// Optional feature macro: PS2_RX_BREAK_DECODE_EN. When defined, E0/F0
// prefixes are absorbed and reported through rx_ext/rx_break on the next
// byte; when undefined every good byte is delivered and rx_ext/rx_break are 0.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_timeout,
    output logic       busy,
    output logic       rx_break,
    output logic       rx_ext
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    // The pulse is registered, so expiry is decided on the cycle where the
    // counter steps onto TIMEOUT_CYC-1; rx_timeout then lands exactly
    // TIMEOUT_CYC cycles after the last fall pulse.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 2);

    logic fall;
    logic data_s;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data_s   (data_s)
    );

    ps2_state_t       state_reg,   state_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg,   shift_next;
    logic             parity_reg,  parity_next;
    logic [CNT_W-1:0] wd_reg,      wd_next;
    logic [7:0]       rx_data_reg, rx_data_next;
    logic             valid_reg,   valid_next;
    logic             perr_reg,    perr_next;
    logic             ferr_reg,    ferr_next;
    logic             to_reg,      to_next;
    logic             good_byte;
    logic             parity_ok;
    logic             stop_ok;

`ifdef PS2_RX_BREAK_DECODE_EN
    logic ext_reg,      ext_next;
    logic brk_reg,      brk_next;
    logic ext_pend_reg, ext_pend_next;
    logic brk_pend_reg, brk_pend_next;
`endif

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        rx_data_next = rx_data_reg;
        valid_next   = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;
        to_next      = 1'b0;
        good_byte    = 1'b0;
        parity_ok    = odd_parity_ok(shift_reg, parity_reg);
        stop_ok      = data_s;

        if (state_reg == IDLE || fall) begin
            wd_next = '0;
        end else begin
            wd_next = wd_reg + CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (fall) begin
                    if (!data_s) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    shift_next   = {data_s, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_next = data_s;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if (parity_ok && stop_ok) begin
                        good_byte = 1'b1;
                    end else begin
                        perr_next = ~parity_ok;
                        ferr_next = ~stop_ok;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A fall pulse always takes priority over expiry.
        if (state_reg != IDLE && !fall && wd_reg == WD_LAST) begin
            state_next   = IDLE;
            to_next      = 1'b1;
            wd_next      = '0;
            shift_next   = '0;
            bit_cnt_next = '0;
        end

`ifdef PS2_RX_BREAK_DECODE_EN
        ext_next      = ext_reg;
        brk_next      = brk_reg;
        ext_pend_next = ext_pend_reg;
        brk_pend_next = brk_pend_reg;
        if (good_byte) begin
            if (shift_reg == PS2_EXT_CODE) begin
                ext_pend_next = 1'b1;
            end else if (shift_reg == PS2_BREAK_CODE) begin
                brk_pend_next = 1'b1;
            end else begin
                rx_data_next  = shift_reg;
                valid_next    = 1'b1;
                ext_next      = ext_pend_reg;
                brk_next      = brk_pend_reg;
                ext_pend_next = 1'b0;
                brk_pend_next = 1'b0;
            end
        end
        // A broken sequence must not tag an unrelated later byte.
        if (perr_next || ferr_next || to_next) begin
            ext_pend_next = 1'b0;
            brk_pend_next = 1'b0;
        end
`else
        if (good_byte) begin
            rx_data_next = shift_reg;
            valid_next   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            wd_reg      <= '0;
            rx_data_reg <= 8'h00;
            valid_reg   <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            to_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
            wd_reg      <= wd_next;
            rx_data_reg <= rx_data_next;
            valid_reg   <= valid_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            to_reg      <= to_next;
        end
    end

`ifdef PS2_RX_BREAK_DECODE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_reg      <= 1'b0;
            brk_reg      <= 1'b0;
            ext_pend_reg <= 1'b0;
            brk_pend_reg <= 1'b0;
        end else begin
            ext_reg      <= ext_next;
            brk_reg      <= brk_next;
            ext_pend_reg <= ext_pend_next;
            brk_pend_reg <= brk_pend_next;
        end
    end

    assign rx_ext   = ext_reg;
    assign rx_break = brk_reg;
`else
    assign rx_ext   = 1'b0;
    assign rx_break = 1'b0;
`endif

    assign rx_data       = rx_data_reg;
    assign rx_valid      = valid_reg;
    assign rx_parity_err = perr_reg;
    assign rx_frame_err  = ferr_reg;
    assign rx_timeout    = to_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame -- self-checking bench for ps2_rx_frame. Expected receive
// events are queued as frames are driven and compared as the DUT pulses.
// Works with or without PS2_RX_BREAK_DECODE_EN defined.
module tb_ps2_rx_frame;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int HALF        = 20;   // ps2_clk half period in clk cycles

`ifdef PS2_RX_BREAK_DECODE_EN
    localparam bit DECODE = 1'b1;
`else
    localparam bit DECODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_parity_err, rx_frame_err, rx_timeout;
    logic       busy, rx_break, rx_ext;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_timeout    (rx_timeout),
        .busy          (busy),
        .rx_break      (rx_break),
        .rx_ext        (rx_ext)
    );

    always #5 clk = ~clk;

    // flags = {timeout, frame_err, parity_err, valid}
    typedef struct packed {
        logic [3:0] flags;
        logic [7:0] data;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] last_good = 8'h00;
    logic       ext_pend = 1'b0, brk_pend = 1'b0;
    logic       cur_ext = 1'b0, cur_brk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every output pulse pops one expected event.
    always @(negedge clk) begin
        if (!reset && (rx_valid || rx_parity_err || rx_frame_err || rx_timeout)) begin
            ev_t e;
            $display("rx event t=%0t flags=%b data=%02h ext=%0b brk=%0b", $time,
                     {rx_timeout, rx_frame_err, rx_parity_err, rx_valid}, rx_data, rx_ext, rx_break);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {rx_timeout, rx_frame_err, rx_parity_err, rx_valid}, 0);
            end else begin
                e = exp_q.pop_front();
                check("flags",    {rx_timeout, rx_frame_err, rx_parity_err, rx_valid}, e.flags);
                check("rx_data",  rx_data,  e.data);
                check("rx_ext",   rx_ext,   e.ext);
                check("rx_break", rx_break, e.brk);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_error(input logic [3:0] flags);
        ev_t e;
        ext_pend = 1'b0;
        brk_pend = 1'b0;
        e.flags = flags;
        e.data  = last_good;
        e.ext   = cur_ext;
        e.brk   = cur_brk;
        exp_q.push_back(e);
    endtask

    task automatic expect_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        ev_t e;
        if (par_ok && stop_ok) begin
            if (DECODE && b == 8'hE0) begin
                ext_pend = 1'b1;
            end else if (DECODE && b == 8'hF0) begin
                brk_pend = 1'b1;
            end else begin
                cur_ext   = ext_pend;
                cur_brk   = brk_pend;
                ext_pend  = 1'b0;
                brk_pend  = 1'b0;
                last_good = b;
                e.flags = 4'b0001;
                e.data  = b;
                e.ext   = cur_ext;
                e.brk   = cur_brk;
                exp_q.push_back(e);
            end
        end else begin
            push_error({1'b0, ~stop_ok, ~par_ok, 1'b0});
        end
    endtask

    task automatic glitch();
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN - 2);
        ps2_clk = 1'b1;
    endtask

    // bits[0] goes out first; an optional low glitch follows bit glitch_at.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
            if (i == glitch_at) begin
                wait_cyc(HALF);
                glitch();
            end
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit par_ok, input bit stop_bit);
        logic par;
        par = ~(^b);
        if (!par_ok) par = ~par;
        return {stop_bit, par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_bit, input int glitch_at);
        expect_frame(b, par_ok, stop_bit);
        send_bits(make_frame(b, par_ok, stop_bit), 11, glitch_at);
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) wait_cyc(1);
        check("drain", exp_q.size(), 0);
        check("busy_idle", busy, 0);
        ps2_data = 1'b1;
        wait_cyc(30);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 1 ms");
        $fatal(1, "bench timed out");
    end

    initial begin
        wait_cyc(3);
        check("rst_rx_data", rx_data, 0);
        check("rst_valid",   rx_valid, 0);
        check("rst_flags",   {rx_timeout, rx_frame_err, rx_parity_err}, 0);
        check("rst_busy",    busy, 0);
        check("rst_extbrk",  {rx_ext, rx_break}, 0);
        reset = 1'b0;
        wait_cyc(20);

        // Good byte, then parity error, stop error, and the same byte clean.
        send_frame(8'h1C, 1, 1'b1, -1);
        send_frame(8'h5A, 0, 1'b1, -1);
        send_frame(8'h5A, 1, 1'b0, -1);
        send_frame(8'h5A, 1, 1'b1, -1);
        // Both flags in one frame.
        send_frame(8'h33, 0, 1'b0, -1);

        // Bad start bit in IDLE.
        push_error(4'b0100);
        send_bits(11'b1, 1, -1);
        wait_cyc(30);
        check("start_err_drain", exp_q.size(), 0);

        // Short glitches in IDLE and mid-DATA must be ignored.
        glitch();
        wait_cyc(30);
        check("glitch_idle_busy", busy, 0);
        send_frame(8'h1C, 1, 1'b1, 3);

        // Stall after 4 data bits; timeout lands TIMEOUT_CYC cycles after the
        // fall pulse, which itself trails the pin by FILTER_LEN+3 cycles.
        push_error(4'b1000);
        send_bits(make_frame(8'h1C, 1, 1'b1), 4, -1);
        ps2_data = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        for (int k = 1; k <= FILTER_LEN + TIMEOUT_CYC + 5; k++) begin
            @(posedge clk);
            #1;
            if (k == HALF) ps2_clk = 1'b1;
            if (k == FILTER_LEN + TIMEOUT_CYC + 2) begin
                check("to_early", rx_timeout, 0);
                check("busy_before_to", busy, 1);
            end
            if (k == FILTER_LEN + TIMEOUT_CYC + 3) begin
                check("to_pulse", rx_timeout, 1);
                check("busy_after_to", busy, 0);
            end
        end
        ps2_data = 1'b1;
        wait_cyc(30);
        check("to_drain", exp_q.size(), 0);
        send_frame(8'h1C, 1, 1'b1, -1);

        // Reset mid-frame aborts silently; reception resumes afterwards.
        send_bits(make_frame(8'h29, 1, 1'b1), 3, -1);
        wait_cyc(5);
        check("busy_mid", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_pulses", {rx_timeout, rx_frame_err, rx_parity_err, rx_valid}, 0);
        last_good = 8'h00;
        ext_pend = 1'b0; brk_pend = 1'b0; cur_ext = 1'b0; cur_brk = 1'b0;
        ps2_data = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(20);
        send_frame(8'h1C, 1, 1'b1, -1);

        // Prefix sequences.
        send_frame(8'hE0, 1, 1'b1, -1);
        send_frame(8'hF0, 1, 1'b1, -1);
        send_frame(8'h75, 1, 1'b1, -1);
        send_frame(8'h6B, 1, 1'b1, -1);
        send_frame(8'hE0, 1, 1'b1, -1);
        send_frame(8'h12, 0, 1'b1, -1);
        send_frame(8'h75, 1, 1'b1, -1);

        check("final_queue", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
